matrix_mem_bridge: RTL and testbench
====================================

MATRIX_MEM_BRIDGE -- requirements
Module: matrix_mem_bridge

Interface
REQ-001 Parameters SHALL be: DATA_W, default `TYPE_BW, word width; ADDR_W, default 8, words = 2**ADDR_W; READ_LAT, default 2, cycles from capture to mem_opdone (1..15).
REQ-002 Ports SHALL be: clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_operation  input  2  engine request: 00 none, 01 read, 11 write, 10 reserved.
REQ-005 addr_i  input  32  engine word address.
REQ-006 data_i  input  DATA_W  engine write data.
REQ-007 mem_opdone  output  1  one-cycle completion pulse to engine.
REQ-008 data_o  output  DATA_W  read data to engine, valid in the mem_opdone cycle.
REQ-009 host_req  input  1  host preload/readback request.
REQ-010 host_we  input  1  host write (1) or read (0).
REQ-011 host_addr  input  ADDR_W  host word address.
REQ-012 host_wdata  input  DATA_W  host write data.
REQ-013 host_ready  output  1  host request accepted this cycle.
REQ-014 host_rvalid  output  1  one-cycle pulse, host_rdata valid.
REQ-015 host_rdata  output  DATA_W  host read data.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 err_oob  output  1  sticky: an engine access had addr_i >= 2**ADDR_W.

Function
REQ-018 Storage SHALL be a register array of 2**ADDR_W words of DATA_W bits; contents are not cleared by reset.
REQ-019 FSM states SHALL be IDLE, ENG_WAIT, ENG_DONE, GAP, HOST_WAIT.
REQ-020 IDLE: mem_operation of 01 or 11 captures op, addr_i, data_i and goes to ENG_WAIT; 00 and 10 are no request.
REQ-021 IDLE with engine request and host_req in the same cycle: engine wins; host_ready stays 0; host holds its request.
REQ-022 IDLE with host_req and no engine request: host_ready = 1 combinationally; write commits at that edge; next state GAP for write, HOST_WAIT for read.
REQ-023 ENG_WAIT: a latency counter SHALL run; after READ_LAT-1 cycles in ENG_WAIT, go to ENG_DONE; captured values are used, and input changes during the wait are ignored.
REQ-024 ENG_DONE: mem_opdone = 1 for exactly this cycle; read drives data_o = mem[addr]; write commits mem[addr] <= data at this edge; next state GAP.
REQ-025 Engine read-to-mem_opdone latency SHALL be READ_LAT cycles from the capture edge; a write completes with the same latency.
REQ-026 GAP: one cycle during which no request is sampled; next state IDLE; this allows the engine to drop or re-address mem_operation after mem_opdone.
REQ-027 A back-to-back engine read with mem_operation held at 01 and addr_i changed after mem_opdone SHALL be captured as a new request in the first IDLE cycle after GAP.
REQ-028 HOST_WAIT: one cycle; host_rvalid = 1 with host_rdata = mem[captured host_addr]; next state IDLE.
REQ-029 Out-of-range engine address (addr_i[31:ADDR_W] != 0): a read returns data_o = 0, a write is dropped, mem_opdone still pulses, and err_oob is set.
REQ-030 data_o and host_rdata SHALL hold their last value between pulses.
REQ-031 err_oob SHALL clear only on reset.

Reset
REQ-032 reset low SHALL immediately force: state IDLE, mem_opdone 0, data_o 0, host_ready 0, host_rvalid 0, host_rdata 0, busy 0, err_oob 0, latency counter 0.
REQ-033 Reset mid-transaction SHALL abandon the pending access; no write commits, and no mem_opdone is issued after release.
REQ-034 The first request is sampled on the first rising edge with reset high.

Verification
REQ-035 Host writes 4,2,4,2 to addr 0..3 and 1..8 to addr 4..11 -> one host_ready per write; reading addr 5 returns host_rvalid with 2.
REQ-036 READ_LAT=2: engine op 01 at addr 6 captured at edge 0 -> mem_opdone high at edge 2 with data_o = stored word, then exactly one GAP cycle.
REQ-037 Engine holds op 01 and steps addr 0..4 after each mem_opdone -> five mem_opdone pulses returning words 0..4 in order, no duplicates.
REQ-038 Engine write 11 of 0xDEAD to addr 20 with host_req in the same cycle -> engine served first; host_ready asserted only after GAP; host read of 20 returns 0xDEAD.
REQ-039 Engine read at addr 0x100 with ADDR_W=8 -> mem_opdone with data_o 0, err_oob 1 until reset.
REQ-040 reset low during ENG_WAIT of a write to addr 3 -> outputs at reset values, mem[3] unchanged, no mem_opdone after release.

Source files
------------

// File: rtl/matrix_mem_bridge.sv
// matrix_mem_bridge: single-port word memory shared by a matrix engine
// (fixed-latency read/write handshake) and a host preload/readback port.
// The engine has priority; every access is followed by a one-cycle gap.
`ifndef TYPE_BW
`define TYPE_BW 16
`endif

module matrix_mem_bridge #(
  parameter int unsigned DATA_W   = `TYPE_BW,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_operation,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              mem_opdone,
  output logic [DATA_W-1:0] data_o,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              err_oob
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LAST_I = (READ_LAT > 1) ? READ_LAT - 2 : 0;
  localparam logic [3:0]  LAT_LAST = LAST_I[3:0];

  typedef enum logic [2:0] {IDLE, ENG_WAIT, ENG_DONE, GAP, HOST_WAIT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [3:0]          lat_cnt;
  logic                op_we;
  logic [ADDR_W-1:0]   eng_addr;
  logic [DATA_W-1:0]   eng_data;
  logic                eng_oob;

  logic                eng_req;
  logic                addr_oob;
  logic                eng_wr_en;
  logic                fin_we;
  logic [ADDR_W-1:0]   fin_addr;
  logic                fin_oob;

  // 01 and 11 are requests; 00 and 10 are ignored
  assign eng_req   = mem_operation[0];
  assign addr_oob  = (addr_i >> ADDR_W) != 32'd0;
  assign host_ready = reset && (state == IDLE) && host_req && !eng_req;
  assign busy      = (state != IDLE);
  assign eng_wr_en = (state == ENG_DONE) && op_we && !eng_oob;

  // With READ_LAT=1 completion is set up in the capture cycle itself, so the
  // completion path takes the live inputs while IDLE and the captured copy otherwise.
  assign fin_we   = (state == IDLE) ? mem_operation[1]     : op_we;
  assign fin_addr = (state == IDLE) ? addr_i[ADDR_W-1:0]   : eng_addr;
  assign fin_oob  = (state == IDLE) ? addr_oob             : eng_oob;

  // Storage writes: host writes at acceptance, engine writes leaving ENG_DONE
  always_ff @(posedge clk) begin
    if (host_ready && host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (eng_wr_en) begin
      mem[eng_addr] <= eng_data;
    end
  end

  // Arbitration / latency FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      mem_opdone  <= 1'b0;
      data_o      <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      err_oob     <= 1'b0;
      op_we       <= 1'b0;
      eng_addr    <= '0;
      eng_data    <= '0;
      eng_oob     <= 1'b0;
    end else begin
      mem_opdone  <= 1'b0;
      host_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (eng_req) begin
            op_we    <= mem_operation[1];
            eng_addr <= addr_i[ADDR_W-1:0];
            eng_data <= data_i;
            eng_oob  <= addr_oob;
            lat_cnt  <= '0;
            if (READ_LAT <= 1) begin
              mem_opdone <= 1'b1;
              if (!fin_we) data_o <= fin_oob ? '0 : mem[fin_addr];
              if (fin_oob) err_oob <= 1'b1;
              state <= ENG_DONE;
            end else begin
              state <= ENG_WAIT;
            end
          end else if (host_req) begin
            if (host_we) begin
              state <= GAP;
            end else begin
              host_rdata  <= mem[host_addr];
              host_rvalid <= 1'b1;
              state       <= HOST_WAIT;
            end
          end
        end
        ENG_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt    <= '0;
            mem_opdone <= 1'b1;
            if (!fin_we) data_o <= fin_oob ? '0 : mem[fin_addr];
            if (fin_oob) err_oob <= 1'b1;
            state <= ENG_DONE;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        ENG_DONE:  state <= GAP;
        GAP:       state <= IDLE;
        HOST_WAIT: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mem_bridge.sv
// Scoreboard bench for matrix_mem_bridge: drivers push expected responses,
// a negedge monitor pops and compares on every mem_opdone / host_rvalid.
module tb_matrix_mem_bridge;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mem_operation = '0;
  logic [31:0]   addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          mem_opdone;
  logic [DW-1:0] data_o;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          busy;
  logic          err_oob;

  matrix_mem_bridge #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .mem_operation(mem_operation), .addr_i(addr_i), .data_i(data_i),
    .mem_opdone(mem_opdone), .data_o(data_o),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .busy(busy), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          oob;
  } eng_exp_t;

  eng_exp_t      eng_q[$];
  logic [DW-1:0] host_q[$];

  // Reference model: plain memory image plus the sticky/held output values
  logic [DW-1:0] model_mem [256];
  logic          model_oob = 1'b0;
  logic [DW-1:0] model_data_o = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset) begin
      if (mem_opdone) begin
        if (eng_q.size() == 0) begin
          check("eng_opdone_unexpected", 32'd1, 32'd0);
        end else begin
          eng_exp_t e;
          e = eng_q.pop_front();
          check("eng_data_o", 32'(data_o), 32'(e.data));
          check("eng_err_oob", 32'(err_oob), 32'(e.oob));
        end
      end
      if (host_rvalid) begin
        if (host_q.size() == 0) begin
          check("host_rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          logic [DW-1:0] h;
          h = host_q.pop_front();
          check("host_rdata", 32'(host_rdata), 32'(h));
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    wait_idle();
    if (we) model_mem[a] = d;
    else    host_q.push_back(model_mem[a]);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      if (host_ready) got = 1;
    end
    check("host_ready_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic eng_op(input logic we, input logic [31:0] a, input logic [DW-1:0] d, input bit hold);
    eng_exp_t e;
    bit oob;
    int n = 0;
    bit got = 0;
    wait_idle();
    oob = (a >= 32'd256);
    if (!we)       model_data_o = oob ? '0 : model_mem[a[7:0]];
    else if (!oob) model_mem[a[7:0]] = d;
    if (oob) model_oob = 1'b1;
    e.data = model_data_o;
    e.oob  = model_oob;
    eng_q.push_back(e);
    mem_operation = we ? 2'b11 : 2'b01; addr_i = a; data_i = d;
    @(posedge clk); #1;
    // inputs wander during the wait; only the captured request may matter
    addr_i = $urandom; data_i = DW'($urandom);
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (mem_opdone) got = 1;
    end
    check("eng_latency", 32'(n), 32'(RL));
    @(posedge clk); #1;
    if (!hold) mem_operation = 2'b00;
    @(negedge clk);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_no_opdone", 32'(mem_opdone), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_opdone"}, 32'(mem_opdone), 32'd0);
    check({tag, "_data_o"}, 32'(data_o), 32'd0);
    check({tag, "_host_ready"}, 32'(host_ready), 32'd0);
    check({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
    check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_oob"}, 32'(err_oob), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, first_rdy, opdone_n, pulses;
    logic [DW-1:0] old3;
    logic [31:0] a;
    logic [DW-1:0] d;

    host_req = 1'b1; // must be masked while in reset
    @(negedge clk); #1;
    check_reset_outputs("rst0");
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Directed preload: 4,2,4,2 at 0..3 and 1..8 at 4..11
    for (int i = 0; i < 4; i++) host_op(1'b1, AW'(i), (i % 2 == 0) ? DW'(4) : DW'(2));
    for (int i = 4; i < 12; i++) host_op(1'b1, AW'(i), DW'(i - 3));
    host_op(1'b0, AW'(5), '0);
    for (int i = 12; i < 256; i++) host_op(1'b1, AW'(i), DW'($urandom));

    // Single engine read, then a held back-to-back read sweep
    eng_op(1'b0, 32'd6, '0, 0);
    for (int i = 0; i < 5; i++) eng_op(1'b0, 32'(i), '0, i < 4);

    // Engine write and host read arriving together: engine first
    wait_idle();
    model_mem[20] = 16'hDEAD;
    begin
      eng_exp_t e;
      e.data = model_data_o; e.oob = model_oob;
      eng_q.push_back(e);
    end
    host_q.push_back(16'hDEAD);
    mem_operation = 2'b11; addr_i = 32'd20; data_i = 16'hDEAD;
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'(20);
    #1;
    check("contend_ready_idle", 32'(host_ready), 32'd0);
    n = 0; first_rdy = 0; opdone_n = 0;
    while (n < 20 && first_rdy == 0) begin
      @(negedge clk);
      n++;
      if (host_ready) first_rdy = n;
      if (mem_opdone) begin
        opdone_n = n;
        @(posedge clk); #1;
        mem_operation = 2'b00;
      end
    end
    check("contend_opdone_cycle", 32'(opdone_n), 32'(RL));
    check("contend_ready_cycle", 32'(first_rdy), 32'(RL + 2));
    @(posedge clk); #1;
    host_req = 1'b0;

    // Out-of-range engine read and write
    eng_op(1'b0, 32'h0000_0100, '0, 0);
    eng_op(1'b1, 32'h8000_0014, 16'h1234, 0);
    host_op(1'b0, AW'(20), '0);

    // Randomized mix of host and engine traffic
    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 7) == 0) ? (32'h100 + $urandom) : 32'($urandom_range(0, 255));
      d = DW'($urandom);
      case ($urandom_range(0, 3))
        0: host_op(1'b1, a[AW-1:0], d);
        1: host_op(1'b0, a[AW-1:0], d);
        2: eng_op(1'b0, a, d, 0);
        default: eng_op(1'b1, a, d, 0);
      endcase
    end

    // Reset during the wait of an engine write to addr 3
    wait_idle();
    old3 = model_mem[3];
    mem_operation = 2'b11; addr_i = 32'd3; data_i = ~old3;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_oob = 1'b0; model_data_o = '0;
    mem_operation = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_opdone) pulses++;
    end
    check("rst_no_late_opdone", 32'(pulses), 32'd0);
    host_op(1'b0, AW'(3), '0);
    eng_op(1'b0, 32'd3, '0, 0);

    wait_idle();
    repeat (2) @(negedge clk);
    check("eng_q_drained", 32'(eng_q.size()), 32'd0);
    check("host_q_drained", 32'(host_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
